wifi_fifo_scheduler: RTL

Frame-level controller for the PHY's shared 1-bit bit FIFO. Arbitrates round-robin between two bit-serial requesters (e.g. SIGNAL-field and DATA-field generators), streams the granted frame into the FIFO without overflow, and drains it to the downstream stage under backpressure. One frame is in flight at a time. `frame_done` pulses when the frame's last bit has left the FIFO.

---
 rtl/wifi_fifo_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wifi_fifo_scheduler.sv
// Frame-level controller for the PHY's shared 1-bit FIFO. It grants one of two
// bit-serial requesters round-robin, streams the frame in, and drains it under backpressure.
module wifi_fifo_scheduler #(
    parameter int LW    = 16,
    parameter int DEPTH = 4,
    parameter int OW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic          din0,
    input  logic          din1,
    output logic          ack0,
    output logic          ack1,
    output logic          fifo_we,
    output logic          fifo_din,
    output logic          fifo_re,
    input  logic          fifo_valid,
    input  logic          fifo_dout,
    input  logic          out_ready,
    output logic          out_data,
    output logic          out_valid,
    output logic          busy,
    output logic          grant,
    output logic          frame_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          grant_r;
    logic          rr_r;
    logic          pend_r;
    logic [LW-1:0] wr_rem_r;
    logic [LW-1:0] rd_rem_r;
    logic [OW-1:0] occ_r;

    logic          wr_en_s;
    logic          rd_en_s;
    logic          pick_s;
    logic [LW-1:0] len_sel_s;

    // Write and read qualifiers; only one read may be outstanding so no bit is lost.
    always_comb begin
        wr_en_s   = (state_r == S_WRITE) && (occ_r < OW'(DEPTH)) && (wr_rem_r != {LW{1'b0}});
        rd_en_s   = ((state_r == S_WRITE) || (state_r == S_DRAIN)) && out_ready
                    && (occ_r != {OW{1'b0}}) && !pend_r;
        pick_s    = (req0 && req1) ? rr_r : req1;
        len_sel_s = grant_r ? len1 : len0;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req0 || req1) state_next_s = S_GRANT;
                else              state_next_s = S_IDLE;
            end
            S_GRANT: begin
                if (len_sel_s == {LW{1'b0}}) state_next_s = S_DONE;
                else                         state_next_s = S_WRITE;
            end
            S_WRITE: begin
                if (wr_en_s && (wr_rem_r == LW'(1))) state_next_s = S_DRAIN;
                else                                 state_next_s = S_WRITE;
            end
            S_DRAIN: begin
                if (rd_rem_r == {LW{1'b0}}) state_next_s = S_DONE;
                else                        state_next_s = S_DRAIN;
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output decode from state and qualifiers.
    always_comb begin
        fifo_we    = wr_en_s;
        fifo_din   = wr_en_s & (grant_r ? din1 : din0);
        ack0       = wr_en_s & ~grant_r;
        ack1       = wr_en_s & grant_r;
        fifo_re    = rd_en_s;
        out_data   = fifo_dout;
        out_valid  = fifo_valid;
        busy       = (state_r != S_IDLE);
        grant      = grant_r;
        frame_done = (state_r == S_DONE);
    end

    // Grant, round-robin pointer, bit counters, occupancy and outstanding-read flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_r  <= 1'b0;
            rr_r     <= 1'b0;
            pend_r   <= 1'b0;
            wr_rem_r <= {LW{1'b0}};
            rd_rem_r <= {LW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else begin
            if ((state_r == S_IDLE) && (req0 || req1)) grant_r <= pick_s;
            if (state_r == S_DONE) rr_r <= ~grant_r;
            if (state_r == S_GRANT) begin
                wr_rem_r <= len_sel_s;
                rd_rem_r <= len_sel_s;
            end else begin
                if (wr_en_s) wr_rem_r <= wr_rem_r - LW'(1);
                if (fifo_valid && (rd_rem_r != {LW{1'b0}})) rd_rem_r <= rd_rem_r - LW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   occ_r <= occ_r + OW'(1);
                2'b01:   occ_r <= occ_r - OW'(1);
                default: occ_r <= occ_r;
            endcase
            if (rd_en_s)         pend_r <= 1'b1;
            else if (fifo_valid) pend_r <= 1'b0;
            else                 pend_r <= pend_r;
        end
    end

endmodule
